aib_rx_word_aligner: RTL
========================

# aib_rx_word_aligner

Receive-side word aligner sitting directly downstream of the AIB IO buffer array. It consumes each IO's DDR sample pair (data0, data1) in the retime clock domain and detects the DDR half-cycle phase from a marker lane. It then assembles aligned 2*NumIo-bit words and qualifies them with a lock state machine before they reach the adapter FIFO.

## Interface
- NumIo, 96: number of IOs; matches the IO block width.
- MarkerIo, 0: index of the IO lane carrying the word marker.
- LockCount, 8: consecutive good markers required to lock; must be at least 2.
- ErrLimit, 4: consecutive bad markers in LOCKED that drop lock; must be at least 1.
- i_clk, input, 1: retime clock; the same clock as the IO block's i_rx_retime_clk.
- i_rst_n, input, 1: asynchronous, active-low reset.
- c_align_en, input, 1: 1 enables marker alignment; 0 selects bypass.
- i_rx_data0, input, 1 x [NumIo-1:0] unpacked: first-half samples from the IO block.
- i_rx_data1, input, 1 x [NumIo-1:0] unpacked: second-half samples from the IO block.
- o_rx_word, output, 2*NumIo: aligned word; [NumIo-1:0] holds the first half, the upper bits hold the second half.
- o_rx_valid, output, 1: o_rx_word is aligned and valid this cycle.
- o_rx_lock, output, 1: FSM is in LOCKED.
- o_rx_phase, output, 1: selected DDR phase; 0 = normal, 1 = swapped.

## Operation
- Input stage: every cycle, register the data into d0_q and d1_q (packed), and copy the old d1_q into d1_qq.
- The transmitter drives the marker lane as first half = 1, second half = 0, on every word.
- Marker checks:
  - good_n = d0_q[MarkerIo]==1 && d1_q[MarkerIo]==0.
  - good_s = d1_qq[MarkerIo]==1 && d0_q[MarkerIo]==0.
  - good = good_n when phase==0, otherwise good_s.
- Word formation:
  - Phase 0: {d1_q, d0_q}.
  - Phase 1: {d0_q, d1_qq}.
  - The marker bit is passed through unmodified.
- FSM states SEARCH, CHECK, LOCKED:
  - SEARCH: good_n gives phase=0, cnt=1, go to CHECK. Otherwise good_s gives phase=1, cnt=1, go to CHECK. If both hold, normal phase wins. Otherwise stay in SEARCH.
  - CHECK: good with cnt==LockCount-1 goes to LOCKED and clears errcnt. Good otherwise increments cnt. Bad goes to SEARCH with cnt=0.
  - LOCKED: good clears errcnt. Bad increments errcnt; when errcnt reaches ErrLimit, go to SEARCH with cnt=0.
- Phase is updated only on the SEARCH to CHECK transition.
- Counter widths are $clog2(LockCount+1) and $clog2(ErrLimit+1).
- Bypass (c_align_en=0):
  - FSM is held in SEARCH; cnt, errcnt and phase are forced to 0.
  - o_rx_word = {d1_q, d0_q} every cycle.
  - o_rx_valid=1 from the second clock after reset release; o_rx_lock=0.
- Changing c_align_en in either direction forces SEARCH on the next edge. The software contract is to change it only while traffic is idle.
- Reset values:
  - o_rx_word=0, o_rx_valid=0, o_rx_lock=0, o_rx_phase=0.
  - State SEARCH; d0_q, d1_q, d1_qq, cnt and errcnt all 0.

## Timing
- Latency from input to o_rx_word is 2 clocks: the input register plus the output register.
- In phase 1, the first half comes from one cycle earlier still.
- o_rx_valid and o_rx_lock are registered from the next-state value, so they stay aligned with the word they qualify.
- Lock: o_rx_valid rises together with the word whose marker was the LockCount-th good marker.
- Loss of lock: o_rx_valid falls together with the word carrying the ErrLimit-th bad marker.
- A bad marker below ErrLimit still outputs its word with valid=1; the marker lane exposes the error downstream.
- Asserting i_rst_n low mid-word clears all outputs immediately (asynchronous reset); no partial word is emitted afterwards.

## Configuration
- AIB_RX_ALIGN_STATS_EN, when defined, adds:
  - o_err_count (16 bits, saturating): counts bad markers observed while LOCKED.
  - o_lock_loss_count (8 bits, saturating): counts LOCKED to SEARCH transitions.
  - Both reset to 0 and clear when c_align_en=0.
- Undefined: those ports and counters are absent; all other behaviour is identical.

## Structure
- Package aib_rx_align_pkg holds:
  - The state enum typedef (SEARCH, CHECK, LOCKED).
  - The stats counter width localparams.
- Sub-module aib_rx_align_fsm contains the state, cnt, errcnt and phase logic. It takes good_n and good_s as inputs. The top level holds the data registers and the word mux.

## Test plan
- Normal phase, LockCount=8: send marker pattern 1/0 with incrementing data. o_rx_lock rises after the 8th marker. o_rx_word equals {d1,d0} delayed by 2 cycles, with o_rx_phase=0.
- Swapped phase: delay the transmit half by one DDR half-cycle. The FSM locks with o_rx_phase=1, and every word matches the transmitted word with the first half taken from the previous cycle's data1.
- CHECK abort: send 5 good markers, then 1 bad. FSM returns to SEARCH, and o_rx_valid never asserts until 8 fresh good markers arrive.
- Loss of lock, ErrLimit=4: in LOCKED, send 3 bad, 1 good, 3 bad. Lock is held. A 4th consecutive bad drops o_rx_valid and o_rx_lock on that word. With stats on, o_lock_loss_count=1 and o_err_count=7.
- Bypass: c_align_en=0 with random data. o_rx_valid=1 and o_rx_word={d1,d0}, delayed by 2 cycles, independent of the marker lane.
- Reset mid-lock: assert i_rst_n low. All outputs go to 0 asynchronously. After release, the FSM restarts in SEARCH with o_rx_phase=0.

Source files
------------

// File: rtl/aib_rx_align_pkg.sv
// aib_rx_align_pkg: shared state encoding and stats counter widths for the AIB RX word aligner
package aib_rx_align_pkg;
  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_e;
  localparam int ErrCntW = 16;
  localparam int LossCntW = 8;
endpackage

// File: rtl/aib_rx_align_fsm.sv
// aib_rx_align_fsm: marker-driven DDR phase search and lock qualification; AIB_RX_ALIGN_STATS_EN adds error/lock-loss counters
module aib_rx_align_fsm
  import aib_rx_align_pkg::*;
#(
  parameter int LockCount = 8,
  parameter int ErrLimit = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic c_align_en,
  input  logic good_n_i,
  input  logic good_s_i,
  output logic phase_d_o,
  output logic phase_q_o,
  output logic valid_d_o,
  output logic lock_d_o
`ifdef AIB_RX_ALIGN_STATS_EN
  ,
  output logic [ErrCntW-1:0] err_count_o,
  output logic [LossCntW-1:0] lock_loss_count_o
`endif
);
  localparam int CntW = $clog2(LockCount + 1);
  localparam int ErrW = $clog2(ErrLimit + 1);
  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ErrW-1:0] err_q, err_d, err_inc;
  logic phase_q, phase_d, en_q, prime_q, good;
  // next-state: search picks a phase (normal wins ties), check counts good markers, locked tolerates up to ErrLimit-1 bad in a row
  always_comb begin
    good = phase_q ? good_s_i : good_n_i;
    err_inc = err_q + 1'b1;
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    phase_d = phase_q;
    case (state_q)
      SEARCH: if (good_n_i || good_s_i) begin
        state_d = CHECK;
        cnt_d = CntW'(1);
        phase_d = !good_n_i;
      end
      CHECK: if (!good) begin
        state_d = SEARCH;
        cnt_d = '0;
      end else if (cnt_q == CntW'(LockCount - 1)) begin
        state_d = LOCKED;
        err_d = '0;
      end else cnt_d = cnt_q + 1'b1;
      LOCKED: begin
        err_d = good ? '0 : err_inc;
        if (!good && err_inc == ErrW'(ErrLimit)) begin
          state_d = SEARCH;
          cnt_d = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
    if (!c_align_en || !en_q) begin
      state_d = SEARCH;
      cnt_d = '0;
      err_d = '0;
      phase_d = c_align_en ? phase_q : 1'b0;
    end
    valid_d_o = c_align_en ? state_d == LOCKED : prime_q;
    lock_d_o = state_d == LOCKED;
  end
  // state, counters and phase; prime_q delays bypass valid until the input register holds real data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SEARCH;
      cnt_q <= '0;
      err_q <= '0;
      phase_q <= 1'b0;
      en_q <= 1'b0;
      prime_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      phase_q <= phase_d;
      en_q <= c_align_en;
      prime_q <= 1'b1;
    end
  end
  assign phase_d_o = phase_d;
  assign phase_q_o = phase_q;
`ifdef AIB_RX_ALIGN_STATS_EN
  logic [ErrCntW-1:0] errs_q;
  logic [LossCntW-1:0] loss_q;
  // saturating counts of bad markers while locked and of lock losses, cleared in bypass
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      errs_q <= '0;
      loss_q <= '0;
    end else if (!c_align_en) begin
      errs_q <= '0;
      loss_q <= '0;
    end else begin
      if (state_q == LOCKED && !good && !(&errs_q)) errs_q <= errs_q + 1'b1;
      if (state_q == LOCKED && state_d == SEARCH && !(&loss_q)) loss_q <= loss_q + 1'b1;
    end
  end
  assign err_count_o = errs_q;
  assign lock_loss_count_o = loss_q;
`endif
endmodule

// File: rtl/aib_rx_word_aligner.sv
// aib_rx_word_aligner: registers DDR IO samples, detects half-cycle phase from a marker lane and emits qualified 2*NumIo-bit words; AIB_RX_ALIGN_STATS_EN adds stats ports
module aib_rx_word_aligner
  import aib_rx_align_pkg::*;
#(
  parameter int NumIo = 96,
  parameter int MarkerIo = 0,
  parameter int LockCount = 8,
  parameter int ErrLimit = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               c_align_en,
  input  logic               i_rx_data0 [NumIo],
  input  logic               i_rx_data1 [NumIo],
  output logic [2*NumIo-1:0] o_rx_word,
  output logic               o_rx_valid,
  output logic               o_rx_lock,
  output logic               o_rx_phase
`ifdef AIB_RX_ALIGN_STATS_EN
  ,
  output logic [ErrCntW-1:0]  o_err_count,
  output logic [LossCntW-1:0] o_lock_loss_count
`endif
);
  logic [NumIo-1:0] d0_d, d1_d, d0_q, d1_q, d1_qq;
  logic [2*NumIo-1:0] word_d;
  logic good_n, good_s, phase_d, valid_d, lock_d;
  for (genvar i = 0; i < NumIo; i++) begin : g_pack
    assign d0_d[i] = i_rx_data0[i];
    assign d1_d[i] = i_rx_data1[i];
  end
  assign good_n = d0_q[MarkerIo] & ~d1_q[MarkerIo];
  assign good_s = d1_qq[MarkerIo] & ~d0_q[MarkerIo];
  assign word_d = phase_d ? {d0_q, d1_qq} : {d1_q, d0_q};
  aib_rx_align_fsm #(
    .LockCount(LockCount),
    .ErrLimit (ErrLimit)
  ) u_fsm (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .c_align_en(c_align_en),
    .good_n_i  (good_n),
    .good_s_i  (good_s),
    .phase_d_o (phase_d),
    .phase_q_o (o_rx_phase),
    .valid_d_o (valid_d),
    .lock_d_o  (lock_d)
`ifdef AIB_RX_ALIGN_STATS_EN
    ,
    .err_count_o      (o_err_count),
    .lock_loss_count_o(o_lock_loss_count)
`endif
  );
  // input stage plus output stage; d1_qq keeps the previous second half for the swapped phase
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      d0_q <= '0;
      d1_q <= '0;
      d1_qq <= '0;
      o_rx_word <= '0;
      o_rx_valid <= 1'b0;
      o_rx_lock <= 1'b0;
    end else begin
      d0_q <= d0_d;
      d1_q <= d1_d;
      d1_qq <= d1_q;
      o_rx_word <= word_d;
      o_rx_valid <= valid_d;
      o_rx_lock <= lock_d;
    end
  end
endmodule
